// File: rtl/card_pkg.sv
// Shared types and helpers for the blackjack deck controller, the hand-total
// calculator and the card renderer.
package card_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHUFFLE,
        PICK,
        PROBE,
        DELIVER
    } state_t;

    localparam int DECK_SIZE      = 52;
    localparam int RANKS_PER_SUIT = 13;

    typedef enum logic {
        PLAYER = 1'b0,
        DEALER = 1'b1
    } dest_t;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Repeated subtraction avoids a divider for idx/13 and idx%13.
    function automatic card_t decode_card(input logic [5:0] idx);
        card_t      c;
        logic [5:0] r;
        r      = idx;
        c.suit = 2'd0;
        for (int s = 0; s < 3; s++) begin
            if (r >= 6'(RANKS_PER_SUIT)) begin
                r      = r - 6'(RANKS_PER_SUIT);
                c.suit = c.suit + 2'd1;
            end
        end
        c.rank = 4'(r) + 4'd1;
        return c;
    endfunction

endpackage

// File: rtl/deck_lfsr.sv
// Free-running 16-bit pseudo-random source for card selection.
module deck_lfsr
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deck controller: arbitrates player/dealer draw requests, draws cards without
// replacement from the deck and handles reshuffle.
module card_dealer #(
    parameter int          DECK_SIZE = 52,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       player_req,
    input  logic       dealer_req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic       card_dest,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic       empty_reject,
    output logic [5:0] cards_left,
    output logic       busy
);
    import card_pkg::*;

    localparam logic [5:0] DECK_N   = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

    state_t                 state, state_next;
    logic [15:0]            lfsr;
    logic [DECK_SIZE-1:0]   used;
    logic [5:0]             idx;
    logic [5:0]             left;
    logic                   player_pend, dealer_pend, shuffle_pend;
    dest_t                  dest, last_dest, grant_dest;
    card_t                  card;
    logic                   reject;
    logic                   do_shuffle, do_grant, do_pick, do_reject, hit;
    logic                   clear_player, clear_dealer;
    logic                   unused_lfsr_hi;

    deck_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:6];

    always_comb begin
        if (player_pend && dealer_pend) begin
            grant_dest = dest_t'(~last_dest);
        end else begin
            grant_dest = dest_t'(dealer_pend);
        end
        do_shuffle   = (state == IDLE) && shuffle_pend;
        do_grant     = (state == IDLE) && !shuffle_pend && (player_pend || dealer_pend);
        do_pick      = do_grant && (left != 6'd0);
        do_reject    = do_grant && (left == 6'd0);
        hit          = (state == PROBE) && !used[idx];
        clear_player = (hit && dest == PLAYER) || (do_reject && grant_dest == PLAYER);
        clear_dealer = (hit && dest == DEALER) || (do_reject && grant_dest == DEALER);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (do_shuffle) begin
                    state_next = SHUFFLE;
                end else if (do_pick) begin
                    state_next = PICK;
                end
            end
            SHUFFLE: state_next = IDLE;
            PICK:    state_next = PROBE;
            PROBE: begin
                if (hit) begin
                    state_next = DELIVER;
                end
            end
            DELIVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latching; a pulse on an already-pending side is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            player_pend  <= 1'b0;
            dealer_pend  <= 1'b0;
            shuffle_pend <= 1'b0;
        end else begin
            player_pend  <= player_pend ? !clear_player : player_req;
            dealer_pend  <= dealer_pend ? !clear_dealer : dealer_req;
            shuffle_pend <= shuffle || (shuffle_pend && !do_shuffle);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used      <= '0;
            left      <= DECK_N;
            dest      <= PLAYER;
            last_dest <= DEALER;
            card      <= '0;
            reject    <= 1'b0;
        end else begin
            reject <= do_reject;
            if (do_shuffle) begin
                used <= '0;
                left <= DECK_N;
            end
            if (do_grant) begin
                dest <= grant_dest;
            end
            if (hit) begin
                used[idx] <= 1'b1;
                left      <= left - 6'd1;
                card      <= decode_card(idx);
            end
            if (state == DELIVER) begin
                last_dest <= dest;
            end
        end
    end

    // Linear probe from the random start slot until a free card is found.
    always_ff @(posedge clk) begin
        if (do_pick) begin
            idx <= (lfsr[5:0] < DECK_N) ? lfsr[5:0] : (lfsr[5:0] - DECK_N);
        end else if (state == PROBE && used[idx]) begin
            idx <= (idx == LAST_IDX) ? 6'd0 : (idx + 6'd1);
        end
    end

    assign card_valid   = (state == DELIVER);
    assign card_dest    = dest;
    assign card_rank    = card.rank;
    assign card_suit    = card.suit;
    assign empty_reject = reject;
    assign cards_left   = left;
    assign busy         = (state != IDLE);

endmodule
